// File: rtl/full_adder.sv
// full_adder: registered ripple-carry adder built from bit-level full-adder cells
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             out_valid
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_valid;

    assign w_c[0] = C;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_s[i]   = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
    end

    // load the ripple result on accepted inputs; out_valid echoes in_valid one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_s;
                r_carry <= w_c[WIDTH];
            end
        end
    end

    assign Sum       = r_sum;
    assign Carry     = r_carry;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: checks 1-bit and 4-bit registered adders against an arithmetic model
module tb_full_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       v1, a1, b1, c1, s1, co1, ov1;
    logic       v4, c4, co4, ov4;
    logic [3:0] a4, b4, s4;
    int         checks = 0;
    int         errors = 0;

    full_adder #(.WIDTH(1)) u_fa1 (
        .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .C(c1),
        .Sum(s1), .Carry(co1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(4)) u_fa4 (
        .clk(clk), .rst(rst), .in_valid(v4), .A(a4), .B(b4), .C(c4),
        .Sum(s4), .Carry(co4), .out_valid(ov4)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
        return 2'(a) + 2'(b) + 2'(c);
    endfunction

    function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return 5'(a) + 5'(b) + 5'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        v4 = 0; a4 = 0; b4 = 0; c4 = 0;
        #1;
        checks++;
        if ({co1, s1, ov1, co4, s4, ov4} !== 8'b0) begin
            errors++;
            $display("FAIL reset_async got %b required 0", {co1, s1, ov1, co4, s4, ov4});
        end
        v1 = 1; a1 = 1; b1 = 1; c1 = 1;
        v4 = 1; a4 = 15; b4 = 15; c4 = 1;
        step();
        step();
        checks++;
        if ({co1, s1, ov1, co4, s4, ov4} !== 8'b0) begin
            errors++;
            $display("FAIL reset_held got %b required 0", {co1, s1, ov1, co4, s4, ov4});
        end
        v1 = 0; v4 = 0;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_truth_table();
        logic [2:0] pat [8] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b101, 3'b011, 3'b111};
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = pat[i];
            v1 = 1;
            e = ref1(a1, b1, c1);
            step();
            checks++;
            if ({co1, s1, ov1} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL truth_%b got carry=%b sum=%b ov=%b required carry=%b sum=%b ov=1",
                         pat[i], co1, s1, ov1, e[1], e[0]);
            end
        end
        v1 = 0;
    endtask

    task automatic test_hold();
        a1 = 1; b1 = 1; c1 = 1; v1 = 1;
        step();
        checks++;
        if ({co1, s1, ov1} !== 3'b111) begin
            errors++;
            $display("FAIL hold_capture got %b required 111", {co1, s1, ov1});
        end
        a1 = 0; b1 = 0; c1 = 0; v1 = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({co1, s1, ov1} !== 3'b110) begin
                errors++;
                $display("FAIL hold_cycle%0d got %b required 110", i, {co1, s1, ov1});
            end
        end
    endtask

    task automatic test_async_reset();
        a1 = 1; b1 = 1; c1 = 1; v1 = 1;
        a4 = 9; b4 = 6; c4 = 1; v4 = 1;
        step();
        v1 = 0; v4 = 0;
        checks++;
        if ({co1, s1, co4, s4} !== {1'b1, 1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL pre_reset got %b required 11 10000", {co1, s1, co4, s4});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({co1, s1, ov1, co4, s4, ov4} !== 8'b0) begin
            errors++;
            $display("FAIL async_reset_mid_cycle got %b required 0", {co1, s1, ov1, co4, s4, ov4});
        end
        @(negedge clk);
        a1 = 1; b1 = 1; c1 = 1; v1 = 1;
        a4 = 15; b4 = 15; c4 = 1; v4 = 1;
        step();
        checks++;
        if ({co1, s1, ov1, co4, s4, ov4} !== 8'b0) begin
            errors++;
            $display("FAIL reset_priority got %b required 0", {co1, s1, ov1, co4, s4, ov4});
        end
        v1 = 0; v4 = 0;
        #3;
        rst = 1'b0;
        step();
        checks++;
        if ({co1, s1, ov1, co4, s4, ov4} !== 8'b0) begin
            errors++;
            $display("FAIL post_reset_no_capture got %b required 0", {co1, s1, ov1, co4, s4, ov4});
        end
    endtask

    task automatic test_wrap();
        logic [8:0] vec [3] = '{{4'd15, 4'd0, 1'b1}, {4'd9, 4'd6, 1'b0}, {4'd15, 4'd15, 1'b1}};
        logic [4:0] e;
        for (int i = 0; i < 3; i++) begin
            {a4, b4, c4} = vec[i];
            v4 = 1;
            e = ref4(a4, b4, c4);
            step();
            checks++;
            if ({co4, s4, ov4} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL wrap_%0d got carry=%b sum=%0d required carry=%b sum=%0d",
                         i, co4, s4, e[4], e[3:0]);
            end
        end
        v4 = 0;
    endtask

    task automatic test_back_to_back();
        logic [8:0] vec [4] = '{{4'd3, 4'd4, 1'b0}, {4'd7, 4'd8, 1'b1}, {4'd0, 4'd0, 1'b0}, {4'd8, 4'd8, 1'b0}};
        logic [4:0] e;
        {a4, b4, c4} = vec[0];
        v4 = 1;
        for (int i = 0; i < 4; i++) begin
            e = ref4(a4, b4, c4);
            step();
            checks++;
            if ({co4, s4, ov4} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL b2b_%0d got carry=%b sum=%0d ov=%b required carry=%b sum=%0d ov=1",
                         i, co4, s4, ov4, e[4], e[3:0]);
            end
            if (i < 3) {a4, b4, c4} = vec[i+1];
            else v4 = 0;
        end
        step();
        checks++;
        if ({co4, s4, ov4} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_drain got %b required 100000", {co4, s4, ov4});
        end
    endtask

    task automatic test_random();
        logic [1:0] e1 = '0;
        logic [4:0] e4 = '0;
        logic       ev1, ev4;
        for (int k = 0; k < 300; k++) begin
            v1 = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            v4 = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            if (v1) e1 = ref1(a1, b1, c1);
            if (v4) e4 = ref4(a4, b4, c4);
            ev1 = v1;
            ev4 = v4;
            step();
            checks++;
            if ({co1, s1, ov1} !== {e1, ev1}) begin
                errors++;
                $display("FAIL rand1_%0d got %b required %b", k, {co1, s1, ov1}, {e1, ev1});
            end
            checks++;
            if ({co4, s4, ov4} !== {e4, ev4}) begin
                errors++;
                $display("FAIL rand4_%0d got %b required %b", k, {co4, s4, ov4}, {e4, ev4});
            end
        end
        v1 = 0; v4 = 0;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_hold();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
